// File: rtl/fir_pkg.sv
// Shared FIR definitions: control-bit positions carried through the multiplier
// pipeline and the accumulator width helper.
package fir_pkg;

  localparam int CTRL_VALID = 0;
  localparam int CTRL_LAST  = 1;
  localparam int CTRL_W     = 2;

  // Wide enough that TAPS full-scale products of two width-bit operands never overflow.
  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_accumulator.sv
// Sums TAPS consecutive multiplier products into one FIR output sample and
// presents it through a one-entry valid/ready holding register.
module fir_mac_accumulator
  import fir_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TAPS      = 8,
  parameter int OUT_WIDTH = acc_width(WIDTH, TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   product,
  input  logic [CTRL_W-1:0]    ctrls,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 tap_error
);

  localparam int              CNT_W    = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic [OUT_WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]     tap_cnt_r;
  logic [OUT_WIDTH-1:0] sum_s;
  logic                 at_end_s;
  logic                 complete_s;
  logic                 frame_err_s;

  assign at_end_s = (tap_cnt_r == LAST_TAP);

  // Running sum and sample framing; a missing last at the final tap still closes the sample.
  always_comb begin
    sum_s       = acc_r + OUT_WIDTH'(product);
    complete_s  = 1'b0;
    frame_err_s = 1'b0;
    if (ctrls[CTRL_VALID]) begin
      if (ctrls[CTRL_LAST]) begin
        complete_s  = 1'b1;
        frame_err_s = !at_end_s;
      end else begin
        complete_s  = at_end_s;
        frame_err_s = at_end_s;
      end
    end else begin
      complete_s  = 1'b0;
      frame_err_s = 1'b0;
    end
  end

  // Accumulator and tap counter; invalid cycles leave both untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= {OUT_WIDTH{1'b0}};
      tap_cnt_r <= {CNT_W{1'b0}};
    end else if (ctrls[CTRL_VALID]) begin
      if (complete_s) begin
        acc_r     <= {OUT_WIDTH{1'b0}};
        tap_cnt_r <= {CNT_W{1'b0}};
      end else begin
        acc_r     <= sum_s;
        tap_cnt_r <= tap_cnt_r + CNT_W'(1);
      end
    end
  end

  // Output holding register plus sticky overrun and framing flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= {OUT_WIDTH{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      tap_error <= 1'b0;
    end else begin
      if (complete_s) begin
        // A consumer draining the register on this edge frees room for the new sample.
        if (!out_valid || out_ready) begin
          out_data  <= sum_s;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (frame_err_s) begin
        tap_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Directed bench for fir_mac_accumulator with WIDTH=4, TAPS=4 and hand-computed sums.
module tb_fir_mac_accumulator;
  import fir_pkg::*;

  localparam int WIDTH     = 4;
  localparam int TAPS      = 4;
  localparam int OUT_WIDTH = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2*WIDTH-1:0]   product = 8'd0;
  logic [CTRL_W-1:0]    ctrls = 2'b00;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 overrun;
  logic                 tap_error;

  int n_checks = 0;
  int n_errors = 0;

  fir_mac_accumulator #(.WIDTH(WIDTH), .TAPS(TAPS), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .product   (product),
    .ctrls     (ctrls),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .tap_error (tap_error)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input cycle, let it be clocked, then settle 1 time unit past the edge.
  task automatic step(input logic [7:0] p, input logic v, input logic l);
    product            = p;
    ctrls              = 2'b00;
    ctrls[CTRL_VALID]  = v;
    ctrls[CTRL_LAST]   = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(8'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    step(a, 1'b1, 1'b0);
    step(b, 1'b1, 1'b0);
    step(c, 1'b1, 1'b0);
    step(d, 1'b1, 1'b1);
  endtask

  initial begin
    do_reset();
    check_value("rst_out_data", 32'(out_data), 32'd0);
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_overrun", 32'(overrun), 32'd0);
    check_value("rst_tap_error", 32'(tap_error), 32'd0);

    // Full-scale frame.
    out_ready = 1'b1;
    frame(8'd225, 8'd225, 8'd225, 8'd225);
    check_value("fullscale_data", 32'(out_data), 32'd900);
    check_value("fullscale_valid", 32'(out_valid), 32'd1);
    step(8'd0, 1'b0, 1'b0);
    check_value("fullscale_pulse_drop", 32'(out_valid), 32'd0);
    check_value("fullscale_overrun", 32'(overrun), 32'd0);
    check_value("fullscale_tap_error", 32'(tap_error), 32'd0);

    // Back-to-back frames.
    frame(8'd1, 8'd2, 8'd3, 8'd4);
    check_value("b2b_first", 32'(out_data), 32'd10);
    check_value("b2b_first_valid", 32'(out_valid), 32'd1);
    frame(8'd10, 8'd20, 8'd30, 8'd40);
    check_value("b2b_second", 32'(out_data), 32'd100);
    check_value("b2b_second_valid", 32'(out_valid), 32'd1);
    step(8'd0, 1'b0, 1'b0);

    // Consumer stalled across two frames.
    out_ready = 1'b0;
    frame(8'd1, 8'd2, 8'd3, 8'd4);
    check_value("stall_first", 32'(out_data), 32'd10);
    frame(8'd10, 8'd20, 8'd30, 8'd40);
    check_value("stall_hold_data", 32'(out_data), 32'd10);
    check_value("stall_hold_valid", 32'(out_valid), 32'd1);
    check_value("stall_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    step(8'd0, 1'b0, 1'b0);
    check_value("stall_drain_valid", 32'(out_valid), 32'd0);
    check_value("stall_drain_data", 32'(out_data), 32'd10);

    // Accept in the same cycle the next sample completes.
    do_reset();
    out_ready = 1'b0;
    frame(8'd1, 8'd2, 8'd3, 8'd4);
    check_value("same_cycle_first", 32'(out_data), 32'd10);
    step(8'd10, 1'b1, 1'b0);
    step(8'd20, 1'b1, 1'b0);
    step(8'd30, 1'b1, 1'b0);
    out_ready = 1'b1;
    step(8'd40, 1'b1, 1'b1);
    check_value("same_cycle_data", 32'(out_data), 32'd100);
    check_value("same_cycle_valid", 32'(out_valid), 32'd1);
    check_value("same_cycle_overrun", 32'(overrun), 32'd0);
    step(8'd0, 1'b0, 1'b0);
    check_value("same_cycle_drain", 32'(out_valid), 32'd0);

    // Early last.
    step(8'd5, 1'b1, 1'b0);
    check_value("early_last_no_err_yet", 32'(tap_error), 32'd0);
    step(8'd6, 1'b1, 1'b1);
    check_value("early_last_data", 32'(out_data), 32'd11);
    check_value("early_last_tap_error", 32'(tap_error), 32'd1);

    // Missing last: fourth product closes the sample anyway, next frame restarts at tap 0.
    do_reset();
    step(8'd0, 1'b0, 1'b0);
    step(8'd1, 1'b1, 1'b0);
    step(8'd1, 1'b1, 1'b0);
    step(8'd1, 1'b1, 1'b0);
    check_value("missing_last_pending", 32'(out_valid), 32'd0);
    step(8'd1, 1'b1, 1'b0);
    check_value("missing_last_data", 32'(out_data), 32'd4);
    check_value("missing_last_valid", 32'(out_valid), 32'd1);
    check_value("missing_last_tap_error", 32'(tap_error), 32'd1);
    frame(8'd2, 8'd2, 8'd2, 8'd2);
    check_value("missing_last_restart", 32'(out_data), 32'd8);
    step(8'd0, 1'b0, 1'b0);

    // Invalid cycles interleaved, then reset mid-sample.
    step(8'd7, 1'b1, 1'b0);
    step(8'd99, 1'b0, 1'b1);
    step(8'd7, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    check_value("midrst_out_data", 32'(out_data), 32'd0);
    check_value("midrst_out_valid", 32'(out_valid), 32'd0);
    check_value("midrst_overrun", 32'(overrun), 32'd0);
    check_value("midrst_tap_error", 32'(tap_error), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'd7, 1'b1, 1'b0);
    step(8'd50, 1'b0, 1'b0);
    step(8'd7, 1'b1, 1'b0);
    step(8'd60, 1'b0, 1'b1);
    step(8'd7, 1'b1, 1'b0);
    check_value("interleave_pending", 32'(out_valid), 32'd0);
    step(8'd7, 1'b1, 1'b1);
    check_value("interleave_data", 32'(out_data), 32'd28);
    check_value("interleave_valid", 32'(out_valid), 32'd1);
    check_value("interleave_tap_error", 32'(tap_error), 32'd0);
    check_value("interleave_overrun", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
